prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 121 ++++++++++++
 tb/tb_prog_clock_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Programmable multi-channel clock divider with TOGGLE, PULSE, STEP and OFF modes.
// All state and outputs are registered; reset is synchronous and active-high.
module prog_clock_divider #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 25000000,
   localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             halt,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [1:0]       cfg_mode,
   input  logic             step,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);

   typedef enum logic [1:0] {
      ModeToggle = 2'b00,
      ModePulse  = 2'b01,
      ModeStep   = 2'b10,
      ModeOff    = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] div_q   [N_CH];
   logic [CNT_W-1:0] div_d   [N_CH];
   logic [CNT_W-1:0] count_q [N_CH];
   logic [CNT_W-1:0] count_d [N_CH];
   mode_e            mode_q  [N_CH];
   mode_e            mode_d  [N_CH];
   logic [N_CH-1:0]  out_q, out_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic             step_prev_q, step_prev_d;
   logic             step_edge;
   logic             cfg_hit;

   always_comb begin
      step_edge   = step & ~step_prev_q;
      step_prev_d = step;
      // Out-of-range channel indices are possible when N_CH is not a power of two.
      cfg_hit     = cfg_we && (int'(cfg_ch) < int'(N_CH));
      out_d       = out_q;
      tick_d      = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         div_d[i]   = div_q[i];
         mode_d[i]  = mode_q[i];
         count_d[i] = count_q[i];
         if (cfg_hit && (int'(cfg_ch) == i)) begin
            // A write beats any terminal event in the same cycle.
            div_d[i]   = cfg_div;
            mode_d[i]  = mode_e'(cfg_mode);
            count_d[i] = '0;
            out_d[i]   = 1'b0;
         end else if (halt) begin
            out_d[i] = 1'b0;
         end else begin
            unique case (mode_q[i])
               ModeToggle: begin
                  if (count_q[i] == div_q[i]) begin
                     count_d[i] = '0;
                     out_d[i]   = ~out_q[i];
                     tick_d[i]  = 1'b1;
                  end else begin
                     count_d[i] = count_q[i] + CNT_W'(1);
                  end
               end
               ModePulse: begin
                  if (count_q[i] == div_q[i]) begin
                     count_d[i] = '0;
                     out_d[i]   = 1'b1;
                     tick_d[i]  = 1'b1;
                  end else begin
                     count_d[i] = count_q[i] + CNT_W'(1);
                     out_d[i]   = 1'b0;
                  end
               end
               ModeStep: begin
                  count_d[i] = '0;
                  out_d[i]   = step_edge;
                  tick_d[i]  = step_edge;
               end
               ModeOff: begin
                  count_d[i] = '0;
                  out_d[i]   = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            div_q[i]   <= DefDiv;
            mode_q[i]  <= ModeToggle;
            count_q[i] <= '0;
         end
         out_q       <= '0;
         tick_q      <= '0;
         step_prev_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            div_q[i]   <= div_d[i];
            mode_q[i]  <= mode_d[i];
            count_q[i] <= count_d[i];
         end
         out_q       <= out_d;
         tick_q      <= tick_d;
         step_prev_q <= step_prev_d;
      end
   end

   assign clk_out = out_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a cycle model and directed checks feed
// queues that a negedge monitor drains and compares.
module tb_prog_clock_divider;

   localparam int unsigned N_CH  = 5;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DEF   = 6;
   localparam int unsigned CH_W  = 3;

   localparam logic [1:0] MD_TOG  = 2'b00;
   localparam logic [1:0] MD_PUL  = 2'b01;
   localparam logic [1:0] MD_STEP = 2'b10;
   localparam logic [1:0] MD_OFF  = 2'b11;

   logic             clk = 1'b0;
   logic             reset, halt, cfg_we, step;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [1:0]       cfg_mode;
   logic [N_CH-1:0]  clk_out, tick;

   int n_cmp = 0;
   int n_bad = 0;

   prog_clock_divider #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .halt    (halt),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .step    (step),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   // Per-cycle expectation from a behavioural model.
   logic [2*N_CH-1:0] exp_q [$];
   // Directed checks: name, measured value, hand-computed value.
   string             nm_q  [$];
   logic [31:0]       got_q [$];
   logic [31:0]       req_q [$];

   int                m_cnt  [N_CH];
   int                m_div  [N_CH];
   logic [1:0]        m_mode [N_CH];
   logic [N_CH-1:0]   m_out, m_tick;
   logic              m_sprev, m_on = 1'b0, m_edge;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = DEF;
            m_mode[i] = MD_TOG;
         end
         m_out   = '0;
         m_tick  = '0;
         m_sprev = 1'b0;
         m_on    = 1'b1;
      end else if (m_on) begin
         m_edge = step && !m_sprev;
         for (int i = 0; i < int'(N_CH); i++) begin
            m_tick[i] = 1'b0;
            if (cfg_we && int'(cfg_ch) == i) begin
               m_div[i]  = int'(cfg_div);
               m_mode[i] = cfg_mode;
               m_cnt[i]  = 0;
               m_out[i]  = 1'b0;
            end else if (halt) begin
               m_out[i] = 1'b0;
            end else if (m_mode[i] == MD_TOG) begin
               if (m_cnt[i] == m_div[i]) begin
                  m_cnt[i]  = 0;
                  m_out[i]  = !m_out[i];
                  m_tick[i] = 1'b1;
               end else m_cnt[i]++;
            end else if (m_mode[i] == MD_PUL) begin
               m_out[i]  = (m_cnt[i] == m_div[i]);
               m_tick[i] = m_out[i];
               m_cnt[i]  = m_out[i] ? 0 : m_cnt[i] + 1;
            end else if (m_mode[i] == MD_STEP) begin
               m_out[i]  = m_edge;
               m_tick[i] = m_edge;
            end else begin
               m_out[i] = 1'b0;
            end
         end
         m_sprev = step;
      end
      if (m_on) exp_q.push_back({m_out, m_tick});
   end

   int hi_cnt [N_CH];
   int tk_cnt [N_CH];
   initial for (int i = 0; i < int'(N_CH); i++) begin
      hi_cnt[i] = 0;
      tk_cnt[i] = 0;
   end

   always @(negedge clk) begin
      logic [2*N_CH-1:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({clk_out, tick} !== e) begin
            n_bad++;
            $display("FAIL model t=%0t: got clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                     $time, clk_out, tick, e[2*N_CH-1:N_CH], e[N_CH-1:0]);
         end
      end
      while (nm_q.size() != 0) begin
         string       nm;
         logic [31:0] g, r;
         nm = nm_q.pop_front();
         g  = got_q.pop_front();
         r  = req_q.pop_front();
         n_cmp++;
         if (g !== r) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, g, g, r, r);
         end
      end
      for (int i = 0; i < int'(N_CH); i++) begin
         if (clk_out[i] === 1'b1) hi_cnt[i]++;
         if (tick[i] === 1'b1) tk_cnt[i]++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      nm_q.push_back(nm);
      got_q.push_back(got);
      req_q.push_back(req);
   endtask

   task automatic wr(input int ch, input int dv, input logic [1:0] md);
      cfg_we   = 1'b1;
      cfg_ch   = CH_W'(ch);
      cfg_div  = CNT_W'(dv);
      cfg_mode = md;
      cyc(1);
      cfg_we   = 1'b0;
   endtask

   int hs [N_CH];
   int ts [N_CH];

   task automatic snap();
      for (int i = 0; i < int'(N_CH); i++) begin
         hs[i] = hi_cnt[i];
         ts[i] = tk_cnt[i];
      end
   endtask

   initial begin
      int n;
      bit found;
      reset = 1'b1; halt = 1'b0; cfg_we = 1'b0; step = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_mode = MD_TOG;
      cyc(3);
      reset = 1'b0;
      push_chk("reset_outputs", 32'({clk_out, tick}), 32'd0);

      // ch0 div=3 TOGGLE: period 8, tick every 4.
      wr(0, 3, MD_TOG);
      cyc(2); snap(); cyc(40);
      push_chk("ch0_high_cycles", 32'(hi_cnt[0] - hs[0]), 32'd20);
      push_chk("ch0_ticks", 32'(tk_cnt[0] - ts[0]), 32'd10);

      // Rewrite ch0 exactly on its terminal cycle: no toggle, no tick.
      wr(0, 3, MD_TOG);
      cyc(3);
      wr(0, 3, MD_TOG);
      push_chk("write_at_terminal", 32'({clk_out[0], tick[0]}), 32'd0);

      // ch2 div=0 TOGGLE, ch1 div=4 PULSE.
      wr(2, 0, MD_TOG);
      wr(1, 4, MD_PUL);
      cyc(2); snap(); cyc(40);
      push_chk("ch1_high_cycles", 32'(hi_cnt[1] - hs[1]), 32'd8);
      push_chk("ch1_ticks", 32'(tk_cnt[1] - ts[1]), 32'd8);
      push_chk("ch2_high_cycles", 32'(hi_cnt[2] - hs[2]), 32'd20);
      push_chk("ch2_ticks", 32'(tk_cnt[2] - ts[2]), 32'd40);
      push_chk("ch0_unaffected", 32'(hi_cnt[0] - hs[0]), 32'd20);

      // ch3 STEP: long high, then two single-cycle pulses.
      wr(3, 0, MD_STEP);
      cyc(2); snap();
      step = 1'b1; cyc(10); step = 1'b0; cyc(3);
      step = 1'b1; cyc(1);  step = 1'b0; cyc(3);
      step = 1'b1; cyc(1);  step = 1'b0; cyc(3);
      push_chk("step_pulses", 32'(hi_cnt[3] - hs[3]), 32'd3);
      push_chk("step_ticks", 32'(tk_cnt[3] - ts[3]), 32'd3);
      snap();
      halt = 1'b1; cyc(2);
      step = 1'b1; cyc(1); step = 1'b0; cyc(2);
      halt = 1'b0; cyc(4);
      push_chk("step_during_halt", 32'(hi_cnt[3] - hs[3]), 32'd0);

      // ch0 div=9, halt at count 5 for 20 cycles.
      wr(0, 9, MD_TOG);
      cyc(5);
      halt = 1'b1; cyc(1);
      push_chk("halt_first_cycle", 32'({clk_out, tick}), 32'd0);
      cyc(19);
      push_chk("halt_last_cycle", 32'({clk_out, tick}), 32'd0);
      halt = 1'b0;
      n = 0; found = 1'b0;
      while (n < 30 && !found) begin
         cyc(1);
         n++;
         if (tick[0] === 1'b1) found = 1'b1;
      end
      push_chk("halt_resume_edges", 32'(n), 32'd5);

      // Out-of-range writes.
      wr(5, 1, MD_PUL);
      wr(7, 2, MD_OFF);
      cyc(12);

      // Reset beats halt and a simultaneous write.
      reset = 1'b1; halt = 1'b1; cfg_we = 1'b1;
      cfg_ch = '0; cfg_div = 16'd1; cfg_mode = MD_PUL;
      cyc(1);
      reset = 1'b0; halt = 1'b0; cfg_we = 1'b0;
      push_chk("reset_priority", 32'({clk_out, tick}), 32'd0);
      n = 0; found = 1'b0;
      while (n < 20 && !found) begin
         cyc(1);
         n++;
         if (clk_out[0] === 1'b1) found = 1'b1;
      end
      push_chk("reset_first_toggle_edges", 32'(n), DEF + 1);
      push_chk("reset_all_channels_toggle", 32'({clk_out, tick}), 32'h3ff);

      cyc(2);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
